rgb_pwm_driver: RTL and testbench

- Downstream stage of the colour converter: consumes its 24-bit rgb word and drives three LED channels with 8-bit pulse-width modulation.
- New colour values are double-buffered and take effect only at a PWM period boundary, so a period never mixes old and new duty values.
- Sits between the converter output and the board RGB LED pins.

---
 rtl/rgb_pkg.sv | 17 +
 rtl/pwm_channel.sv | 38 +++
 rtl/rgb_pwm_driver.sv | 106 ++++++++++
 tb/tb_rgb_pwm_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared widths and slice positions for the rgb pwm driver
package rgb_pkg;

    localparam int CH_W       = 8;
    localparam int RGB_W      = 24;
    localparam int R_MSB      = 23;
    localparam int G_MSB      = 15;
    localparam int B_MSB      = 7;
    localparam int PWM_PERIOD = 256;

    localparam logic [CH_W-1:0] CNT_MAX = CH_W'(PWM_PERIOD - 1);

    function automatic logic [CH_W-1:0] ch_slice(input logic [RGB_W-1:0] word, input int msb);
        return word[msb -: CH_W];
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one LED channel: duty register plus registered compare output
module pwm_channel
    import rgb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [CH_W-1:0] cnt,
    input  logic            duty_load,
    input  logic [CH_W-1:0] duty_in,
    output logic            pwm
);

    logic [CH_W-1:0] duty_q, duty_d;
    logic            pwm_q, pwm_d;

    always_comb begin
        duty_d = duty_q;
        if (duty_load) begin
            duty_d = duty_in;
        end
        // compare uses the duty in force this cycle, so a reload only affects the next period
        pwm_d = enable && (cnt < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - three-channel 8-bit pwm with period-boundary double buffering
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [RGB_W-1:0] rgb,
    input  logic             load,
    output logic             pending,
    output logic             period_start,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CH_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [RGB_W-1:0] pend_data_q, pend_data_d;
    logic             pending_q, pending_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             boundary;
    logic             duty_load;

    assign tick     = enable && (pre_cnt_q == PRE_MAX);
    assign boundary = tick && (pwm_cnt_q == CNT_MAX);
    // while disabled a waiting colour is applied at once so the first enabled period uses it
    assign duty_load = pending_q && (boundary || !enable);

    always_comb begin
        pre_cnt_d      = '0;
        pwm_cnt_d      = '0;
        pend_data_d    = pend_data_q;
        pending_d      = pending_q;
        period_start_d = boundary;

        if (enable) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        end

        // a load on the transfer edge wins: duty takes the old data, the new word stays pending
        if (load) begin
            pend_data_d = rgb;
            pending_d   = 1'b1;
        end else if (duty_load) begin
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            pend_data_q    <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            pend_data_q    <= pend_data_d;
            pending_q      <= pending_d;
            period_start_q <= period_start_d;
        end
    end

    pwm_channel u_ch_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cnt       (pwm_cnt_q),
        .duty_load (duty_load),
        .duty_in   (ch_slice(pend_data_q, R_MSB)),
        .pwm       (pwm_r)
    );

    pwm_channel u_ch_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cnt       (pwm_cnt_q),
        .duty_load (duty_load),
        .duty_in   (ch_slice(pend_data_q, G_MSB)),
        .pwm       (pwm_g)
    );

    pwm_channel u_ch_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cnt       (pwm_cnt_q),
        .duty_load (duty_load),
        .duty_in   (ch_slice(pend_data_q, B_MSB)),
        .pwm       (pwm_b)
    );

    assign pending      = pending_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed table and sequence checks for rgb_pwm_driver
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en1, load1, en4, load4;
    logic [23:0] rgb1, rgb4;
    logic        pend1, ps1, r1, g1, b1;
    logic        pend4, ps4, r4, g4, b4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .rgb(rgb1), .load(load1),
        .pending(pend1), .period_start(ps1), .pwm_r(r1), .pwm_g(g1), .pwm_b(b1)
    );

    rgb_pwm_driver #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .rgb(rgb4), .load(load4),
        .pending(pend4), .period_start(ps4), .pwm_r(r4), .pwm_g(g4), .pwm_b(b4)
    );

    typedef struct {
        logic [23:0] rgb;
        int          exp_r;
        int          exp_g;
        int          exp_b;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts high samples over n clocks; loads are driven after sample la/lb, hitting edge la+1/lb+1.
    task automatic run1(input int n, input int la, input logic [23:0] va,
                        input int lb, input logic [23:0] vb,
                        output int cr, output int cg, output int cb,
                        output int ps_early, output int ps_last,
                        output int pend_mid, output int pend_end);
        cr = 0; cg = 0; cb = 0; ps_early = 0; ps_last = 0; pend_mid = 0; pend_end = 0;
        for (int i = 0; i < n; i++) begin
            step();
            cr += int'(r1);
            cg += int'(g1);
            cb += int'(b1);
            if (i < n - 1) ps_early += int'(ps1);
            else           ps_last = int'(ps1);
            if (i == la + 1) pend_mid = int'(pend1);
            pend_end = int'(pend1);
            load1 = 1'b0;
            if (i == la) begin rgb1 = va; load1 = 1'b1; end
            if (i == lb) begin rgb1 = vb; load1 = 1'b1; end
        end
    endtask

    task automatic preload1(input logic [23:0] v);
        en1 = 1'b0; load1 = 1'b0;
        step();
        step();
        rgb1 = v; load1 = 1'b1;
        step();
        load1 = 1'b0;
        step();
    endtask

    initial begin
        int cr, cg, cb, pe, pl, pm, pn, cnt;

        vecs[0] = '{24'h8040FF, 128, 64, 255};
        vecs[1] = '{24'h000000, 0, 0, 0};
        vecs[2] = '{24'h01FE7F, 1, 254, 127};
        vecs[3] = '{24'hFFFFFF, 255, 255, 255};

        rst_n = 1'b0; en1 = 1'b0; load1 = 1'b0; rgb1 = '0;
        en4 = 1'b0; load4 = 1'b0; rgb4 = '0;
        step();
        step();
        chk("reset_outputs", int'({r1, g1, b1, pend1, ps1, r4, g4, b4, pend4, ps4}), 0);
        #3 rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            en1 = 1'b0; load1 = 1'b0;
            step();
            step();
            rgb1 = vecs[v].rgb; load1 = 1'b1;
            step();
            chk($sformatf("vec%0d_pending_set", v), int'(pend1), 1);
            load1 = 1'b0;
            step();
            chk($sformatf("vec%0d_pending_applied", v), int'(pend1), 0);
            en1 = 1'b1;
            run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
            chk($sformatf("vec%0d_r_high", v), cr, vecs[v].exp_r);
            chk($sformatf("vec%0d_g_high", v), cg, vecs[v].exp_g);
            chk($sformatf("vec%0d_b_high", v), cb, vecs[v].exp_b);
            chk($sformatf("vec%0d_no_first_ps", v), pe, 0);
            chk($sformatf("vec%0d_wrap_ps", v), pl, 1);
        end

        // double buffering: new colour loaded at pwm_cnt=10 waits for the boundary
        preload1(24'h8040FF);
        en1 = 1'b1;
        run1(256, 9, 24'h000080, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("dbuf_p0_r", cr, 128);
        chk("dbuf_p0_g", cg, 64);
        chk("dbuf_p0_b", cb, 255);
        chk("dbuf_pending_mid", pm, 1);
        chk("dbuf_ps_once", pe + pl, 1);
        chk("dbuf_pending_after", pn, 0);
        run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("dbuf_p1_r", cr, 0);
        chk("dbuf_p1_g", cg, 0);
        chk("dbuf_p1_b", cb, 128);

        // collision: second load lands on the boundary edge
        run1(256, 5, 24'h101010, 254, 24'h202020, cr, cg, cb, pe, pl, pm, pn);
        chk("coll_p2_b", cb, 128);
        chk("coll_pending_kept", pn, 1);
        run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("coll_p3_r", cr, 16);
        chk("coll_p3_g", cg, 16);
        chk("coll_p3_b", cb, 16);
        chk("coll_p3_pending", pn, 0);
        run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("coll_p4_r", cr, 32);
        chk("coll_p4_g", cg, 32);
        chk("coll_p4_b", cb, 32);

        // enable drop at pwm_cnt=50, then re-enable for a full clean period
        preload1(24'hFFFFFF);
        en1 = 1'b1;
        for (int i = 0; i < 50; i++) step();
        chk("drop_high_before", int'({r1, g1, b1}), 7);
        en1 = 1'b0;
        step();
        chk("drop_low_next_edge", int'({r1, g1, b1, ps1}), 0);
        step();
        step();
        en1 = 1'b1;
        run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("reen_r", cr, 255);
        chk("reen_g", cg, 255);
        chk("reen_b", cb, 255);
        chk("reen_no_first_ps", pe, 0);

        // asynchronous reset mid-period with a colour pending
        for (int i = 0; i < 20; i++) step();
        rgb1 = 24'h123456; load1 = 1'b1;
        step();
        load1 = 1'b0;
        chk("rst_pre_pending", int'(pend1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_clear", int'({r1, g1, b1, pend1, ps1}), 0);
        en1 = 1'b0;
        #3 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(r1) + int'(g1) + int'(b1) + int'(pend1) + int'(ps1);
        end
        chk("rst_idle_low", cnt, 0);
        en1 = 1'b1;
        run1(256, -5, '0, -5, '0, cr, cg, cb, pe, pl, pm, pn);
        chk("rst_duty_cleared", cr + cg + cb, 0);
        en1 = 1'b0;

        // PRESCALE=4: red duty 3 -> 12 high clocks in a 1024-clock period
        rgb4 = 24'h030000; load4 = 1'b1;
        step();
        load4 = 1'b0;
        step();
        chk("pre_pending_applied", int'(pend4), 0);
        en4 = 1'b1;
        cr = 0; cg = 0; pe = 0; pl = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            cr += int'(r4);
            cg += int'(g4) + int'(b4);
            if (i < 1023) pe += int'(ps4);
            else          pl = int'(ps4);
        end
        chk("pre_r_high", cr, 12);
        chk("pre_gb_low", cg, 0);
        chk("pre_no_first_ps", pe, 0);
        chk("pre_wrap_ps", pl, 1);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!ps4 && cnt < 2000);
        chk("pre_ps_spacing", cnt, 1024);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
